// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared constants and types for the shared-adder arbiter
package adder_arb_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/adder_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant, gated by the consumer-side accept
module rr_arb2
  import adder_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);
  // A tie goes to the requester that did not win last; otherwise the lone valid wins
  always_comb begin
    grant_idx = (valid == 2'b11) ? ((last_grant == REQ0) ? REQ1 : REQ0) : valid[1];
    grant     = (accept && valid != 2'b00) ? ((grant_idx == REQ1) ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: two requesters share one adder via round-robin; define ADD_SAT_EN to saturate the sum on carry
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready
);
  state_t           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_carry_q;
  logic             res_id_q;
  logic             accept;
  logic             fire;
  logic             grant_idx;
  logic [1:0]       grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH:0]   sum_d;

  assign accept = (state_q == ST_EMPTY) | res_ready;
  assign fire   = |grant;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .accept     (accept),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign res_valid  = (state_q == ST_FULL);
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_id     = res_id_q;

  // Route the granted operands into the single shared adder
  always_comb begin
    op_a  = (grant_idx == REQ1) ? req1_op1 : req0_op1;
    op_b  = (grant_idx == REQ1) ? req1_op2 : req0_op2;
    sum_d = {1'b0, op_a} + {1'b0, op_b};
`ifdef ADD_SAT_EN
    data_d = sum_d[WIDTH] ? '1 : sum_d[WIDTH-1:0];
`else
    data_d = sum_d[WIDTH-1:0];
`endif
  end

  // Output register FSM: load on fire, drop valid when drained, reset wins over fire
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= REQ1;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      res_id_q     <= REQ0;
    end else if (fire) begin
      state_q      <= ST_FULL;
      last_grant_q <= grant_idx;
      res_data_q   <= data_d;
      res_carry_q  <= sum_d[WIDTH];
      res_id_q     <= grant_idx;
    end else if (res_ready) begin
      state_q      <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_adder_share_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_op1 = 8'h00;
  logic [7:0] req0_op2 = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_op1 = 8'h00;
  logic [7:0] req1_op2 = 8'h00;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_id;
  logic       res_ready = 1'b0;

  int errs = 0;
  int checks = 0;
  logic [9:0] sb_q[$];
  logic m_full = 1'b0;
  logic m_last = 1'b1;

`ifdef ADD_SAT_EN
  localparam logic [7:0] OVF_DATA = 8'hFF;
`else
  localparam logic [7:0] OVF_DATA = 8'h10;
`endif

  adder_share_arb #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op1   (req0_op1),
    .req0_op2   (req0_op2),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op1   (req1_op1),
    .req1_op2   (req1_op2),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_SAT_EN
    if (s[8]) s[7:0] = 8'hFF;
`endif
    return s;
  endfunction

  // Drive one cycle of inputs just after the rising edge, then return at the falling edge
  task automatic cyc(input logic rst, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                     input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic rr);
    @(posedge clk);
    #1;
    reset = rst;
    req0_valid = v0; req0_op1 = a0; req0_op2 = b0;
    req1_valid = v1; req1_op1 = a1; req1_op2 = b1;
    res_ready = rr;
    @(negedge clk);
  endtask

  task automatic chk_res(input string name, input logic v, input logic [7:0] d, input logic c, input logic id);
    chk({name, "_valid"}, res_valid, v);
    chk({name, "_data"}, res_data, d);
    chk({name, "_carry"}, res_carry, c);
    chk({name, "_id"}, res_id, id);
  endtask

  // Monitor: tracks expected occupancy/arbitration, pushes expected results on fire, pops on consume
  always @(negedge clk) begin
    logic [1:0] v;
    logic       acc;
    logic       idx;
    logic       fire;
    logic [9:0] e;
    if (reset) begin
      m_full = 1'b0;
      m_last = 1'b1;
      sb_q.delete();
    end else begin
      chk("mon_valid", res_valid, m_full);
      if (m_full && res_ready) begin
        if (sb_q.size() == 0) chk("mon_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("mon_data", res_data, e[7:0]);
          chk("mon_carry", res_carry, e[8]);
          chk("mon_id", res_id, e[9]);
        end
      end
      v    = {req1_valid, req0_valid};
      acc  = !m_full || res_ready;
      idx  = (v == 2'b11) ? ~m_last : v[1];
      fire = acc && (v != 2'b00);
      chk("mon_ready0", req0_ready, fire && !idx);
      chk("mon_ready1", req1_ready, fire && idx);
      if (fire) begin
        sb_q.push_back({idx, idx ? exp_sum(req1_op1, req1_op2) : exp_sum(req0_op1, req0_op2)});
        m_last = idx;
        m_full = 1'b1;
      end else if (res_ready) m_full = 1'b0;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);
    cyc(1'b0, 1'b1, 8'h0A, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("single_ready0", req0_ready, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("single", 1'b1, 8'h0F, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h0A, 8'h1A, 1'b1, 8'h01, 8'h02, 1'b1);
    chk("tie1_ready0", req0_ready, 1'b1);
    chk("tie1_ready1", req1_ready, 1'b0);
    cyc(1'b0, 1'b1, 8'h0A, 8'h1A, 1'b1, 8'h01, 8'h02, 1'b1);
    chk_res("tie1", 1'b1, 8'h24, 1'b0, 1'b0);
    chk("tie2_ready1", req1_ready, 1'b1);
    cyc(1'b0, 1'b1, 8'h0A, 8'h1A, 1'b1, 8'h01, 8'h02, 1'b1);
    chk_res("tie2", 1'b1, 8'h03, 1'b0, 1'b1);
    chk("tie3_ready0", req0_ready, 1'b1);
    cyc(1'b0, 1'b1, 8'h0A, 8'h1A, 1'b1, 8'h01, 8'h02, 1'b1);
    chk_res("tie3", 1'b1, 8'h24, 1'b0, 1'b0);
    chk("tie4_ready1", req1_ready, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("tie4", 1'b1, 8'h03, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h0A, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 8'h12, 1'b0);
      chk("bp_ready1", req1_ready, 1'b0);
      chk_res("bp_hold", 1'b1, 8'h0F, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 8'h12, 1'b1);
    chk("bp_release_ready1", req1_ready, 1'b1);
    chk_res("bp_last", 1'b1, 8'h0F, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hF0, 8'h20, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("bp_next", 1'b1, 8'h42, 1'b0, 1'b1);
    chk("ovf_ready0", req0_ready, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("ovf", 1'b1, OVF_DATA, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("drain", 1'b0, OVF_DATA, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h02, 1'b0);
    chk("mid_ready1", req1_ready, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    chk_res("mid_held", 1'b1, 8'h03, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    chk_res("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h0A, 8'h1A, 1'b1, 8'h01, 8'h02, 1'b1);
    chk("mid_tie_ready0", req0_ready, 1'b1);
    chk("mid_tie_ready1", req1_ready, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk_res("mid_tie", 1'b1, 8'h24, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 8-bit unsigned adder between two requesters, using a round-robin arbiter with a valid/ready handshake on each side.
- Produces a registered result with requester ID and carry; 1-cycle latency, 1 result/cycle throughput.
- Sits between the two pipeline stages that need address/offset adds and the single adder resource, so the datapath carries only one adder.

Parameters:
- WIDTH, 8: operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has operands.
- req0_op1  input  WIDTH  requester 0 operand 1.
- req0_op2  input  WIDTH  requester 0 operand 2.
- req0_ready  output  1  requester 0 accepted this cycle (valid & ready = fire).
- req1_valid  input  1  requester 1 has operands.
- req1_op1  input  WIDTH  requester 1 operand 1.
- req1_op2  input  WIDTH  requester 1 operand 2.
- req1_ready  output  1  requester 1 accepted this cycle.
- res_valid  output  1  result register holds a result.
- res_data  output  WIDTH  sum.
- res_carry  output  1  carry-out of the unsigned add.
- res_id  output  1  requester that produced the result.
- res_ready  input  1  consumer takes the result this cycle.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: res_valid=0, res_data=0, res_carry=0, res_id=0, last_grant=1, state=EMPTY. With last_grant=1, requester 0 wins the first tie.
- State machine over the single output register:
  - EMPTY = res_valid 0. FULL = res_valid 1.
- accept = (state==EMPTY) | res_ready.
- Grant (combinational):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- reqN_ready = accept & grantN. Ready never asserts for a requester whose valid is 0. At most one ready per cycle.
- On fire:
  - {res_carry,res_data} <= opA + opB, computed in WIDTH+1 bits.
  - res_id <= granted index.
  - last_grant <= granted index.
  - state <= FULL.
- last_grant updates only on fire. A grant with no fire (accept=0) leaves the pointer unchanged.
- Transitions:
  - EMPTY, no fire: stay EMPTY.
  - EMPTY, fire: go FULL.
  - FULL, !res_ready: hold all outputs unchanged; both readys 0.
  - FULL, res_ready, no fire: go EMPTY. res_data/res_carry/res_id keep their old values; only res_valid drops.
  - FULL, res_ready, fire: stay FULL with the new result (back-to-back, no bubble).
- Latency: a fire in cycle N gives res_valid=1 with that result in cycle N+1.
- Requesters must hold opN stable while valid & !ready. This is not checked by the block.
- Fairness: with both requesters continuously valid and res_ready=1, grants alternate 0,1,0,1…
- Wrap-around (macro off): sum is modulo 2^WIDTH, and carry reports the overflow.
- Reset mid-operation: any held result is dropped. res_valid=0 and last_grant=1 in the next cycle. Reset has priority over fire.

Optional Feature:
- Macro: ADD_SAT_EN.
- Defined: res_data saturates to all-ones (8'hFF) when the carry is 1; res_carry still reports 1.
- Undefined: res_data is the wrapped sum. The port list is identical in both builds.

Decomposition:
- Package adder_arb_pkg holds:
  - WIDTH default constant.
  - State enum {ST_EMPTY, ST_FULL}.
  - Requester ID constants REQ0=1'b0, REQ1=1'b1.
- One sub-module, rr_arb2: 2-way round-robin grant logic. Inputs: valid[1:0], last_grant, accept. Outputs: grant[1:0], grant_idx.
- The adder itself stays inline as a single WIDTH+1 add.

Test Plan:
- Single request: reset, then req0 op1=8'h0A op2=8'h05 valid, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_data=8'h0F, res_carry=0, res_id=0.
- Tie after reset: both valid, req0 0x0A+0x1A, req1 0x01+0x02, res_ready=1 -> cycle1 grant req0 (result 0x24, id 0); cycle2 grant req1 (result 0x03, id 1); the pair repeats alternating.
- Backpressure: result 0x0F held, res_ready=0 for 3 cycles with req1 valid -> readys stay 0 and res_* stay unchanged; res_ready=1 -> req1 fires that cycle and the new result appears the next cycle, no bubble.
- Overflow: 8'hF0+8'h20 -> without ADD_SAT_EN: res_data=8'h10, res_carry=1; with ADD_SAT_EN: res_data=8'hFF, res_carry=1.
- Drain: FULL, res_ready=1, no valids -> res_valid=0 next cycle, res_data retains its value.
- Reset mid-op: FULL with res_ready=0, then assert reset one cycle -> res_valid=0, res_data=0; then both valid -> req0 granted first.
